// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for the 8080-style LCD write bus: window setup (2A/2B/2C) then RGB565 pixel stream.
// Build macro LCD_ARB_TIMEOUT_EN adds a TIMEOUT-clock limit on pixel stalls; default build waits forever.
module lcd_bus_arbiter #(
    parameter int WR_DIV  = 20,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lcd_init_done,
    input  logic        req0,
    input  logic        req1,
    input  logic [9:0]  x0_0,
    input  logic [9:0]  x1_0,
    input  logic [9:0]  x0_1,
    input  logic [9:0]  x1_1,
    input  logic [8:0]  y0_0,
    input  logic [8:0]  y1_0,
    input  logic [8:0]  y0_1,
    input  logic [8:0]  y1_1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic [15:0] pix0,
    input  logic [15:0] pix1,
    input  logic        pix_valid0,
    input  logic        pix_valid1,
    output logic        pix_ready0,
    output logic        pix_ready1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        busy,
    output logic [15:0] lcd_data,
    output logic        cs,
    output logic        rs,
    output logic        wr
);
    typedef enum logic [1:0] {IDLE, SETUP, PIX, FIN} state_t;
    localparam logic [7:0] RELOAD = 8'(WR_DIV - 1);

    state_t      state;
    logic        owner, last, bad, active, hi;
    logic [7:0]  cnt;
    logic [3:0]  idx;
    logic [19:0] remaining;
    logic [9:0]  lx0, lx1;
    logic [8:0]  ly0, ly1;

    logic        take, pick1, rect_ok, bnd, own_valid;
    logic [9:0]  sx0, sx1;
    logic [8:0]  sy0, sy1;
    logic [10:0] w;
    logic [9:0]  h;
    logic [19:0] npix;
    logic [15:0] own_pix;
    logic [16:0] setup_word;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TW-1:0] tcnt;
`endif

    always_comb begin
        take      = lcd_init_done && (req0 || req1);
        // last = 1 means requester 1 was served last, so requester 0 wins a tie
        pick1     = req1 && (!req0 || !last);
        sx0       = pick1 ? x0_1 : x0_0;
        sx1       = pick1 ? x1_1 : x1_0;
        sy0       = pick1 ? y0_1 : y0_0;
        sy1       = pick1 ? y1_1 : y1_0;
        rect_ok   = (sx1 >= sx0) && (sy1 >= sy0);
        w         = {1'b0, sx1} - {1'b0, sx0} + 11'd1;
        h         = {1'b0, sy1} - {1'b0, sy0} + 10'd1;
        npix      = {9'd0, w} * {10'd0, h};
        own_valid = owner ? pix_valid1 : pix_valid0;
        own_pix   = owner ? pix1 : pix0;
        bnd       = !active || (hi && cnt == 8'd0);
    end

    // {rs, data} for each window setup word
    always_comb begin
        setup_word = {1'b1, 16'h0000};
        case (idx)
            4'd0:    setup_word = {1'b0, 16'h002A};
            4'd1:    setup_word = {1'b1, 14'd0, lx0[9:8]};
            4'd2:    setup_word = {1'b1, 8'd0, lx0[7:0]};
            4'd3:    setup_word = {1'b1, 14'd0, lx1[9:8]};
            4'd4:    setup_word = {1'b1, 8'd0, lx1[7:0]};
            4'd5:    setup_word = {1'b0, 16'h002B};
            4'd6:    setup_word = {1'b1, 15'd0, ly0[8]};
            4'd7:    setup_word = {1'b1, 8'd0, ly0[7:0]};
            4'd8:    setup_word = {1'b1, 15'd0, ly1[8]};
            4'd9:    setup_word = {1'b1, 8'd0, ly1[7:0]};
            4'd10:   setup_word = {1'b0, 16'h002C};
            default: setup_word = {1'b1, 16'h0000};
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && take) begin
            lx0 <= sx0;
            lx1 <= sx1;
            ly0 <= sy0;
            ly1 <= sy1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            bad        <= 1'b0;
            active     <= 1'b0;
            hi         <= 1'b0;
            cnt        <= 8'd0;
            idx        <= 4'd0;
            remaining  <= 20'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            pix_ready0 <= 1'b0;
            pix_ready1 <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            busy       <= 1'b0;
            lcd_data   <= 16'h0000;
            cs         <= 1'b1;
            rs         <= 1'b1;
            wr         <= 1'b1;
`ifdef LCD_ARB_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            pix_ready0 <= 1'b0;
            pix_ready1 <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;

            // Strobe phase sequencing inside a word; word boundaries are handled per state below
            if (active && !bnd) begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    wr  <= 1'b1;
                    hi  <= 1'b1;
                    cnt <= RELOAD;
                end
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        owner     <= pick1;
                        gnt0      <= !pick1;
                        gnt1      <= pick1;
                        bad       <= !rect_ok;
                        remaining <= npix;
                        idx       <= 4'd0;
                        busy      <= 1'b1;
                        cs        <= !rect_ok;
                        state     <= SETUP;
`ifdef LCD_ARB_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end
                end
                SETUP: begin
                    if (bad) begin
                        state <= FIN;
                    end else if (bnd) begin
                        {rs, lcd_data} <= setup_word;
                        wr     <= 1'b0;
                        hi     <= 1'b0;
                        active <= 1'b1;
                        cnt    <= RELOAD;
                        idx    <= idx + 4'd1;
                        if (idx == 4'd10) state <= PIX;
                    end
                end
                PIX: begin
                    if (bnd) begin
                        if (remaining == 20'd0) begin
                            active <= 1'b0;
                            state  <= FIN;
                        end else if (own_valid) begin
                            lcd_data   <= own_pix;
                            rs         <= 1'b1;
                            wr         <= 1'b0;
                            hi         <= 1'b0;
                            active     <= 1'b1;
                            cnt        <= RELOAD;
                            remaining  <= remaining - 20'd1;
                            pix_ready0 <= !owner;
                            pix_ready1 <= owner;
`ifdef LCD_ARB_TIMEOUT_EN
                            tcnt       <= '0;
`endif
                        end else begin
                            active <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
                            if (tcnt == TW'(TIMEOUT - 1)) begin
                                bad   <= 1'b1;
                                state <= FIN;
                            end else begin
                                tcnt <= tcnt + 1'b1;
                            end
`endif
                        end
                    end
                end
                FIN: begin
                    cs    <= 1'b1;
                    busy  <= 1'b0;
                    done0 <= !owner;
                    done1 <= owner;
                    err0  <= bad && !owner;
                    err1  <= bad && owner;
                    last  <= owner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
